// File: rtl/param_issue_queue.sv
// Out-of-order issue queue: oldest-ready select through an age matrix, writeback wakeup and
// relative-tag squash. Defining ISSUE_QUEUE_OCCUPANCY_EN adds the occupancy/high_water outputs.
module param_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int WB_PORTS   = 2,
    parameter int PREG_W     = 6,
    parameter int TAG_W      = 5,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DISPATCH_W-1:0]                disp_valid,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]    disp_src1,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]    disp_src2,
    input  logic [DISPATCH_W-1:0]                disp_src1_rdy,
    input  logic [DISPATCH_W-1:0]                disp_src2_rdy,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]     disp_tag,
    input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] disp_payload,
    output logic                                 disp_ready,
    input  logic [WB_PORTS-1:0]                  wb_valid,
    input  logic [WB_PORTS-1:0][PREG_W-1:0]      wb_preg,
    output logic                                 iss_valid,
    input  logic                                 iss_ready,
    output logic [PREG_W-1:0]                    iss_src1,
    output logic [PREG_W-1:0]                    iss_src2,
    output logic [TAG_W-1:0]                     iss_tag,
    output logic [PAYLOAD_W-1:0]                 iss_payload,
    input  logic                                 flush_valid,
    input  logic [TAG_W-1:0]                     flush_tag,
    input  logic [TAG_W-1:0]                     al_head,
    output logic                                 empty
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0]               occupancy,
    output logic [$clog2(DEPTH):0]               high_water
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0]                rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [DEPTH-1:0][PREG_W-1:0]    src1_q, src1_d, src2_q, src2_d;
    logic [DEPTH-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] pay_q, pay_d;
    // age_q[i][j] = 1 means entry i was dispatched before entry j
    logic [DEPTH-1:0][DEPTH-1:0]     age_q, age_d;
    logic                            init_q, init_d;

    logic [DEPTH-1:0] eligible;
    logic [IDX_W-1:0] sel_idx;
    logic             iss_fire;
    int               free_cnt, need_cnt;

    function automatic logic wb_hit(input logic [PREG_W-1:0] p,
                                    input logic [WB_PORTS-1:0] v,
                                    input logic [WB_PORTS-1:0][PREG_W-1:0] pr);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < WB_PORTS; j++) begin
            if (v[j] && (pr[j] == p)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        logic blocked;
        eligible = valid_q & rdy1_q & rdy2_q;
        sel_idx  = '0;
        blocked  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && age_q[j][i]) blocked = 1'b1;
            end
            if (eligible[i] && !blocked) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        free_cnt = 0;
        need_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) free_cnt++;
        end
        for (int s = 0; s < DISPATCH_W; s++) begin
            if (disp_valid[s]) need_cnt++;
        end
    end

    assign disp_ready  = init_q && !flush_valid && (free_cnt >= need_cnt);
    assign iss_valid   = init_q && !flush_valid && (|eligible);
    assign iss_fire    = iss_valid && iss_ready;
    assign iss_src1    = src1_q[sel_idx];
    assign iss_src2    = src2_q[sel_idx];
    assign iss_tag     = tag_q[sel_idx];
    assign iss_payload = pay_q[sel_idx];
    assign empty       = ~|valid_q;
    assign init_d      = 1'b1;

    always_comb begin
        logic [DEPTH-1:0] taken;
        logic [DEPTH-1:0] occ_mask;
        logic [IDX_W-1:0] e;
        logic             found;
        logic [TAG_W-1:0] rel_e, rel_f;

        valid_d  = valid_q;
        rdy1_d   = rdy1_q;
        rdy2_d   = rdy2_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        tag_d    = tag_q;
        pay_d    = pay_q;
        age_d    = age_q;
        taken    = '0;
        occ_mask = valid_q;
        e        = '0;
        found    = 1'b0;
        rel_f    = flush_tag - al_head;
        rel_e    = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (wb_hit(src1_q[i], wb_valid, wb_preg)) rdy1_d[i] = 1'b1;
            if (wb_hit(src2_q[i], wb_valid, wb_preg)) rdy2_d[i] = 1'b1;
        end

        if (iss_fire) valid_d[sel_idx] = 1'b0;

        // Entries younger than the flushing branch (relative to the active-list head) are squashed
        if (flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                rel_e = tag_q[i] - al_head;
                if (rel_e > rel_f) valid_d[i] = 1'b0;
            end
        end

        // Only entries free at the start of the cycle are allocated; an issuing entry waits a cycle
        if (disp_ready) begin
            for (int s = 0; s < DISPATCH_W; s++) begin
                if (disp_valid[s]) begin
                    found = 1'b0;
                    e     = '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (!found && !valid_q[i] && !taken[i]) begin
                            found = 1'b1;
                            e     = IDX_W'(i);
                        end
                    end
                    taken[e]   = 1'b1;
                    valid_d[e] = 1'b1;
                    src1_d[e]  = disp_src1[s];
                    src2_d[e]  = disp_src2[s];
                    rdy1_d[e]  = disp_src1_rdy[s] | wb_hit(disp_src1[s], wb_valid, wb_preg);
                    rdy2_d[e]  = disp_src2_rdy[s] | wb_hit(disp_src2[s], wb_valid, wb_preg);
                    tag_d[e]   = disp_tag[s];
                    pay_d[e]   = disp_payload[s];
                    age_d[e]   = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        age_d[j][e] = occ_mask[j];
                    end
                    occ_mask[e] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            tag_q   <= '0;
            pay_q   <= '0;
            age_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            tag_q   <= tag_d;
            pay_q   <= pay_d;
            age_q   <= age_d;
            init_q  <= init_d;
        end
    end

`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    logic [CNT_W-1:0] occ_q, occ_d, hw_q, hw_d;

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + CNT_W'(valid_d[i]);
        end
        hw_d = (occ_d > hw_q) ? occ_d : hw_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
            hw_q  <= '0;
        end else begin
            occ_q <= occ_d;
            hw_q  <= hw_d;
        end
    end

    assign occupancy  = occ_q;
    assign high_water = hw_q;
`endif

endmodule

// File: tb/tb_param_issue_queue.sv
// Bench for param_issue_queue: directed scenarios plus random traffic against a queue-based
// reference model kept in dispatch order.
module tb_param_issue_queue;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        disp_valid;
    logic [1:0][5:0]   disp_src1, disp_src2;
    logic [1:0]        disp_src1_rdy, disp_src2_rdy;
    logic [1:0][4:0]   disp_tag;
    logic [1:0][63:0]  disp_payload;
    logic              disp_ready;
    logic [1:0]        wb_valid;
    logic [1:0][5:0]   wb_preg;
    logic              iss_valid, iss_ready;
    logic [5:0]        iss_src1, iss_src2;
    logic [4:0]        iss_tag;
    logic [63:0]       iss_payload;
    logic              flush_valid;
    logic [4:0]        flush_tag, al_head;
    logic              empty;
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    logic [3:0]        occupancy, high_water;
`endif

    param_issue_queue dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_tag(disp_tag), .disp_payload(disp_payload), .disp_ready(disp_ready),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_tag(iss_tag), .iss_payload(iss_payload),
        .flush_valid(flush_valid), .flush_tag(flush_tag), .al_head(al_head),
        .empty(empty)
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
        , .occupancy(occupancy), .high_water(high_water)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  s1, s2;
        logic        r1, r2;
        logic [4:0]  tag;
        logic [63:0] pay;
    } ent_t;

    ent_t mq[$];
    bit   started;
    int   hw_model;
    int   checks, errors;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic woke(input logic [5:0] p);
        for (int j = 0; j < 2; j++) begin
            if (wb_valid[j] && wb_preg[j] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle();
        disp_valid    = '0;
        disp_src1_rdy = '0;
        disp_src2_rdy = '0;
        wb_valid      = '0;
        flush_valid   = 1'b0;
        iss_ready     = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic [5:0] a, input logic ar,
                            input logic [5:0] b, input logic br, input logic [4:0] t);
        disp_src1[s]     = a;
        disp_src1_rdy[s] = ar;
        disp_src2[s]     = b;
        disp_src2_rdy[s] = br;
        disp_tag[s]      = t;
        disp_payload[s]  = {$urandom, $urandom};
        disp_valid[s]    = 1'b1;
    endtask

    // Called with clk low and inputs set; checks outputs, clocks once, advances the model.
    task automatic cycle();
        int   need, sel;
        bit   exp_rdy, exp_iss;
        ent_t n;
        logic [4:0] rel_e, rel_f;
        #1;
        need = int'(disp_valid[0]) + int'(disp_valid[1]);
        exp_rdy = started && !flush_valid && (DEPTH - mq.size() >= need);
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        exp_iss = started && !flush_valid && (sel >= 0);
        chk("disp_ready", disp_ready, exp_rdy);
        chk("iss_valid", iss_valid, exp_iss);
        chk("empty", empty, mq.size() == 0);
        if (exp_iss && iss_valid) begin
            chk("iss_tag", iss_tag, mq[sel].tag);
            chk("iss_src1", iss_src1, mq[sel].s1);
            chk("iss_src2", iss_src2, mq[sel].s2);
            chk("iss_payload", iss_payload, mq[sel].pay);
        end
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
        chk("occupancy", occupancy, mq.size());
        chk("high_water", high_water, hw_model);
`endif
        @(posedge clk);
        if (exp_iss && iss_ready) mq.delete(sel);
        if (flush_valid) begin
            rel_f = flush_tag - al_head;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                rel_e = mq[i].tag - al_head;
                if (rel_e > rel_f) mq.delete(i);
            end
        end
        foreach (mq[i]) begin
            if (woke(mq[i].s1)) mq[i].r1 = 1'b1;
            if (woke(mq[i].s2)) mq[i].r2 = 1'b1;
        end
        if (exp_rdy) begin
            for (int s = 0; s < 2; s++) begin
                if (disp_valid[s]) begin
                    n.s1  = disp_src1[s];
                    n.s2  = disp_src2[s];
                    n.r1  = disp_src1_rdy[s] | woke(disp_src1[s]);
                    n.r2  = disp_src2_rdy[s] | woke(disp_src2[s]);
                    n.tag = disp_tag[s];
                    n.pay = disp_payload[s];
                    mq.push_back(n);
                end
            end
        end
        started = 1'b1;
        if (mq.size() > hw_model) hw_model = mq.size();
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        started  = 1'b0;
        hw_model = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        disp_src1 = '0; disp_src2 = '0; disp_tag = '0; disp_payload = '0;
        wb_preg = '0; flush_tag = '0; al_head = '0;
        idle();
        model_reset();
        rst_n = 1'b0;
        disp_valid = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_disp_ready", disp_ready, 1'b0);
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_empty", empty, 1'b1);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        cycle();
        cycle();

        // two ready entries, issued oldest first
        set_slot(0, 1, 1, 2, 1, 3);
        set_slot(1, 1, 1, 2, 1, 4);
        iss_ready = 1'b1;
        cycle();
        idle(); iss_ready = 1'b1;
        repeat (3) cycle();

        // fill with src1=10 pending, hold full, then one wakeup releases all in order
        idle();
        for (int k = 0; k < 4; k++) begin
            set_slot(0, 10, 0, 1, 1, 5'(10 + 2 * k));
            set_slot(1, 10, 0, 1, 1, 5'(11 + 2 * k));
            cycle();
        end
        set_slot(0, 2, 1, 2, 1, 20);
        set_slot(1, 2, 1, 2, 1, 21);
        repeat (3) cycle();
        idle();
        wb_valid = 2'b10; wb_preg[1] = 10;
        cycle();
        idle(); iss_ready = 1'b1;
        repeat (9) cycle();

        // wakeup coinciding with dispatch
        set_slot(0, 3, 1, 7, 0, 9);
        wb_valid = 2'b01; wb_preg[0] = 7; iss_ready = 1'b1;
        cycle();
        idle(); iss_ready = 1'b1;
        repeat (2) cycle();

        // 7 occupied refuses a 2-wide dispatch until one issues
        idle();
        for (int k = 0; k < 3; k++) begin
            set_slot(0, 20, 0, 1, 1, 5'(2 * k));
            set_slot(1, 20, 0, 1, 1, 5'(2 * k + 1));
            cycle();
        end
        idle();
        set_slot(0, 1, 1, 1, 1, 6);
        cycle();
        set_slot(0, 1, 1, 1, 1, 7);
        set_slot(1, 1, 1, 1, 1, 8);
        iss_ready = 1'b1;
        cycle();
        iss_ready = 1'b0;
        cycle();
        idle();
        wb_valid = 2'b01; wb_preg[0] = 20;
        cycle();
        idle(); iss_ready = 1'b1;
        repeat (10) cycle();

        // squash relative to a wrapped active-list head
        idle();
        al_head = 30;
        set_slot(0, 1, 1, 1, 1, 30); set_slot(1, 1, 1, 1, 1, 31); cycle();
        set_slot(0, 1, 1, 1, 1, 0);  set_slot(1, 1, 1, 1, 1, 1);  cycle();
        idle();
        set_slot(0, 1, 1, 1, 1, 2); cycle();
        idle();
        flush_valid = 1'b1; flush_tag = 0; iss_ready = 1'b1;
        set_slot(0, 1, 1, 1, 1, 5);
        cycle();
        idle(); iss_ready = 1'b1;
        repeat (4) cycle();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 1) == 1)
                    set_slot(s, 6'($urandom_range(0, 7)), 1'($urandom), 6'($urandom_range(0, 7)),
                             1'($urandom), 5'($urandom));
            end
            for (int j = 0; j < 2; j++) begin
                wb_valid[j] = ($urandom_range(0, 3) == 0);
                wb_preg[j]  = 6'($urandom_range(0, 7));
            end
            iss_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0) begin
                flush_valid = 1'b1;
                flush_tag   = 5'($urandom);
                al_head     = 5'($urandom);
            end
            cycle();
        end

        // asynchronous reset mid-operation
        idle();
        set_slot(0, 1, 1, 1, 1, 12); set_slot(1, 1, 1, 1, 1, 13);
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", empty, 1'b1);
        chk("async_rst_iss_valid", iss_valid, 1'b0);
        chk("async_rst_disp_ready", disp_ready, 1'b0);
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
        chk("async_rst_occupancy", occupancy, 0);
        chk("async_rst_high_water", high_water, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            set_slot(0, 1, 1, 1, 1, 5'(k));
            set_slot(1, 1, 1, 1, 1, 5'(k + 8));
            cycle();
        end
        idle(); iss_ready = 1'b1;
        repeat (7) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
